horner_frame_tx: RTL
====================

Name: horner_frame_tx

Overview:
- AXI4-Stream master that builds and transmits one complete Horner job frame for the `top` accelerator's s00 input.
- Frame order: header beat (CAL_NUM), weight beats, 3 matrix-row beats, vector beats. tlast is set on the final beat.
- Body beats come from a host-loaded frame buffer that has a 1-cycle synchronous read.
- Sits between the host/DMA-side frame memory and `top`, and replaces the bench-driven stimulus in system use.

Parameters:
- DATA_WIDTH, 16, bits per lane.
- LANES, 4, lanes per beat; beat width BEAT_W = LANES*DATA_WIDTH = 64.
- ORI_NUM, 8, orientation points.
- INT_NUM, 35, interface points.
- LAY_NUM, 5, layers.
- WEIGHT_NUM, 3*ORI_NUM+INT_NUM-LAY_NUM+3 (=57), weight beats.
- MAT_NUM, 3, matrix-row beats.
- VEC_NUM, ORI_NUM+INT_NUM+LAY_NUM+3 (=51), vector beats.
- BODY_NUM, WEIGHT_NUM+MAT_NUM+VEC_NUM (=111), buffer beats per frame.
- ADDR_W, $clog2(BODY_NUM) (=7), buffer address width.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send a frame; honoured only when busy=0.
- cal_num  in  BEAT_W  header payload, latched on an accepted start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last beat's handshake.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  ADDR_W  frame-buffer read address, 0..BODY_NUM-1.
- rd_data  in  BEAT_W  read data, valid the cycle after rd_en.
- m_axis_tdata  out  BEAT_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final beat only.
- m_axis_tuser  out  2  section tag: 0=header, 1=weight, 2=matrix, 3=vector.

Behaviour:
- Reset values: busy, done, rd_en, m_axis_tvalid, m_axis_tlast = 0. rd_addr, tdata, tuser = 0. FIFO empty. FSM in IDLE.
- Reset asserted mid-frame abandons the frame immediately (tvalid drops asynchronously). No done pulse is issued.
- FSM states: IDLE, HDR, BODY, DRAIN.
- IDLE -> HDR on start: latch cal_num, set busy=1.
- HDR: push header {cal_num, tuser=0} into the output FIFO, then go to BODY.
- BODY: issue reads at rd_addr = 0,1,...,BODY_NUM-1.
  - A read is issued only when FIFO occupancy + reads in flight < 2 (credit rule); overflow is impossible.
  - Returned rd_data is pushed into the FIFO one cycle after rd_en.
  - After the read at BODY_NUM-1 is issued, go to DRAIN.
- DRAIN: when the tlast beat handshakes, pulse done=1 for the next cycle, clear busy, go to IDLE.
- Section tags by body address a:
  - a < WEIGHT_NUM: tuser=1.
  - a < WEIGHT_NUM+MAT_NUM: tuser=2.
  - otherwise: tuser=3.
- tlast is set only for a = BODY_NUM-1.
- Output buffering is a 2-entry FIFO of {tdata, tuser, tlast}; its head drives the m_axis outputs.
- AXIS rules:
  - Once tvalid=1, tdata/tuser/tlast hold until tvalid&&tready.
  - tvalid never depends combinationally on tready.
  - No beat is dropped or duplicated.
- Throughput: 1 beat/cycle while tready=1, so a frame occupies 1+BODY_NUM = 112 consecutive handshake cycles.
- Latency: start accepted at cycle N -> header tvalid at N+1. First body beat becomes available at N+2.
- start while busy=1 is ignored. start in the same cycle as done is accepted (busy already 0 in IDLE). Back-to-back frames are allowed.
- Simultaneous FIFO push and pop keeps occupancy unchanged. Pop from an empty FIFO is impossible because pop is gated by tvalid.

Decomposition:
- Shared package horner_pkg holds:
  - DATA_WIDTH, LANES, ORI_NUM, INT_NUM, LAY_NUM, and derived WEIGHT_NUM, VEC_NUM, NUM_PER_LAYER, BODY_NUM.
  - Section-tag constants TAG_HDR/TAG_WGT/TAG_MAT/TAG_VEC.
  - FSM state enum.
- One sub-module: axis_fifo2 (2-entry register FIFO, parameterised width, with count output for the credit rule).

Test Plan:
1. Reset: areset pulse at arbitrary times -> tvalid=0, busy=0, done=0, rd_en=0 within the reset window.
2. Nominal frame: buffer word[k]=k+1, cal_num=3, tready=1 held.
   - Beat0 data=3, tuser=0.
   - Beats 1..57 data 1..57, tuser=1.
   - Beats 58..60 tuser=2.
   - Beats 61..111 tuser=3, beat 111 data=111 with tlast=1.
   - 112 consecutive handshakes; done one cycle after the last beat.
3. Backpressure: tready pattern 1,0,0,1 repeating, then random -> identical beat sequence, tdata stable while stalled, rd_addr never exceeds 110, FIFO count never exceeds 2.
4. Header stall: tready=0 for 10 cycles after start -> header held unchanged with tvalid=1; rd_en issues at most 1 read before the stall releases.
5. Three frames: start pulsed again on each done cycle, plus a start during busy -> exactly 3 frames, each starting with data=3 and ending with tlast. The extra start is ignored.
6. Mid-frame reset: areset at beat 40 -> tvalid drops at once and no done is issued. After release, start yields a complete frame beginning at header and address 0.

Source files
------------

// File: rtl/horner_pkg.sv
// Shared constants, section tags, FSM state type and beat layout for the
// Horner job-frame transmitter.
package horner_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int LANES         = 4;
  localparam int BEAT_W        = LANES * DATA_WIDTH;
  localparam int ORI_NUM       = 8;
  localparam int INT_NUM       = 35;
  localparam int LAY_NUM       = 5;
  localparam int WEIGHT_NUM    = 3 * ORI_NUM + INT_NUM - LAY_NUM + 3;
  localparam int MAT_NUM       = 3;
  localparam int VEC_NUM       = ORI_NUM + INT_NUM + LAY_NUM + 3;
  // Interface points handled per layer.
  localparam int NUM_PER_LAYER = INT_NUM / LAY_NUM;
  localparam int BODY_NUM      = WEIGHT_NUM + MAT_NUM + VEC_NUM;
  localparam int ADDR_W        = $clog2(BODY_NUM);

  localparam logic [1:0] TAG_HDR = 2'd0;
  localparam logic [1:0] TAG_WGT = 2'd1;
  localparam logic [1:0] TAG_MAT = 2'd2;
  localparam logic [1:0] TAG_VEC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BODY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // One stream beat as held in the output FIFO.
  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [1:0]        user;
    logic              last;
  } beat_t;

  // Section tag of a body beat from its buffer address.
  function automatic logic [1:0] tag_of(input logic [ADDR_W-1:0] addr);
    if (addr < ADDR_W'(WEIGHT_NUM))           return TAG_WGT;
    if (addr < ADDR_W'(WEIGHT_NUM + MAT_NUM)) return TAG_MAT;
    return TAG_VEC;
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry register FIFO. Slot 0 is always the head; the occupancy count is
// exported so the producer can run a credit check against it.
module axis_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         head_valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  // Next slot contents and occupancy for push, pop or both.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case below can leave a value unassigned and infer a latch.
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data_i;
        else                 slot1_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy stays the same; the new word goes behind the survivor.
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Slot and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the data slots are reset as well as the count, because the head
    // slot is the stream data output and must read zero out of reset.
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o       = slot0_q;
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;

endmodule

// File: rtl/horner_frame_tx.sv
// AXI4-Stream master sending one Horner job frame: a header beat carrying
// cal_num followed by BODY_NUM beats read from the host frame buffer.
module horner_frame_tx
  import horner_pkg::*;
(
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [BEAT_W-1:0] cal_num,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BEAT_W-1:0] rd_data,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [1:0]        m_axis_tuser
);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] cal_q, cal_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q;
  logic [1:0]        rd_tag_q;
  logic              rd_last_q;

  beat_t      push_beat, head_beat;
  logic       push, pop, credit_ok;
  logic [1:0] fifo_count;
  logic [2:0] occ_next;

  axis_fifo2 #(.W($bits(beat_t))) u_fifo (
    .clk_i        (aclk),
    .rst_i        (areset),
    .push_i       (push),
    .push_data_i  (push_beat),
    .pop_i        (pop),
    .head_o       (head_beat),
    .head_valid_o (m_axis_tvalid),
    .count_o      (fifo_count)
  );

  // FIFO write side: the header in HDR, otherwise read data returning from
  // the buffer one cycle after its strobe. The two never coincide because no
  // read is outstanding on entry to HDR.
  always_comb begin
    pop  = m_axis_tvalid && m_axis_tready;
    push = (state_q == ST_HDR) || inflight_q;
    if (state_q == ST_HDR) push_beat = '{data: cal_q, user: TAG_HDR, last: 1'b0};
    else                   push_beat = '{data: rd_data, user: rd_tag_q, last: rd_last_q};
    // A new read may go out only if the slot it lands in is guaranteed free
    // after this cycle's push and pop; counting the pop keeps 1 beat/cycle.
    occ_next  = 3'(fifo_count) + 3'(push) - 3'(pop);
    credit_ok = (occ_next < 3'd2);
    rd_en     = ((state_q == ST_HDR) || (state_q == ST_BODY)) && credit_ok;
  end

  // Frame sequencing: accept start, header, body reads, wait for tlast.
  always_comb begin
    state_d   = state_q;
    cal_d     = cal_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cal_d   = cal_num;
          busy_d  = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        // Header is pushed this cycle; read 0 goes out alongside it.
        if (rd_en) rd_addr_d = rd_addr_q + 1'b1;
        state_d = ST_BODY;
      end
      ST_BODY: begin
        if (rd_en) begin
          if (rd_addr_q == ADDR_W'(BODY_NUM - 1)) begin
            rd_addr_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head_beat.last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers and the tag/last pipeline that tracks the pending read.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (areset) begin
      state_q    <= ST_IDLE;
      cal_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      rd_tag_q   <= TAG_HDR;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cal_q      <= cal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_en;
      rd_tag_q   <= tag_of(rd_addr_q);
      rd_last_q  <= (rd_addr_q == ADDR_W'(BODY_NUM - 1));
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_addr      = rd_addr_q;
  assign m_axis_tdata = head_beat.data;
  assign m_axis_tuser = head_beat.user;
  assign m_axis_tlast = head_beat.last;

endmodule
